// File: rtl/sram_dma_pkg.sv
// Shared definitions for the SRAM block-transfer engine: FSM state encoding
// and the copy/fill mode constants.
package sram_dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/sram.sv
// Single-port synchronous SRAM model: one access per cycle, registered read
// data with one-cycle latency. dout holds its value until the next read.
module sram #(
  parameter int N_WIDTH = 32,
  parameter int N_ADDR  = 10
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [N_ADDR-1:0]  addr,
  input  logic [N_WIDTH-1:0] din,
  output logic [N_WIDTH-1:0] dout
);

  logic [N_WIDTH-1:0] mem [2**N_ADDR];

  // Array write and registered read port.
  // NOTE: the storage array has no reset; real SRAM macros power up with
  // undefined contents and a reset loop would not map onto a RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_dma.sv
// Block-transfer engine owning a single-port SRAM: copies len words from
// src to dst (2 cycles/word, ascending) or fills dst with a constant
// (1 cycle/word). Addresses wrap modulo the memory depth.
module sram_dma
  import sram_dma_pkg::*;
#(
  parameter int N_WIDTH = 32,
  parameter int N_ADDR  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [N_ADDR-1:0]  src,
  input  logic [N_ADDR-1:0]  dst,
  input  logic [N_ADDR:0]    len,
  input  logic [N_WIDTH-1:0] fill_val,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               mem_en,
  output logic               mem_we,
  output logic [N_ADDR-1:0]  mem_addr,
  output logic [N_WIDTH-1:0] mem_din,
  input  logic [N_WIDTH-1:0] mem_dout
);

  state_e             state_q;
  logic [N_ADDR:0]    cnt_q;
  logic               mode_q;
  logic [N_ADDR-1:0]  src_q;
  logic [N_ADDR-1:0]  dst_q;
  logic [N_ADDR:0]    len_q;
  logic [N_WIDTH-1:0] fill_q;
  logic               aborted_q;
  logic               abort_pend_q;  // abort seen during RD, applied in WR

  logic [N_ADDR:0]    cnt_inc;
  logic               last_word;
  logic               stop_req;

  // Word-boundary decisions shared by WR and FILL.
  always_comb begin
    cnt_inc   = cnt_q + {{N_ADDR{1'b0}}, 1'b1};
    last_word = (cnt_inc == len_q);
    stop_req  = abort | abort_pend_q;
  end

  // Transfer FSM: parameter latching, word counter and abort bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_q       <= MODE_COPY;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q       <= mode;
            src_q        <= src;
            dst_q        <= dst;
            len_q        <= len;
            fill_q       <= fill_val;
            cnt_q        <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            if (len == '0)             state_q <= DONE;
            else if (mode == MODE_FILL) state_q <= FILL;
            else                        state_q <= RD;
          end
        end
        RD: begin
          if (abort) abort_pend_q <= 1'b1;
          state_q <= WR;
        end
        WR, FILL: begin
          cnt_q <= cnt_inc;
          if (last_word || stop_req) begin
            state_q      <= DONE;
            aborted_q    <= stop_req && !last_word;
            abort_pend_q <= 1'b0;
          end else if (state_q == WR) begin
            state_q <= RD;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // SRAM port and status decode from registered state and parameters.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
    case (state_q)
      RD: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = src_q + cnt_q[N_ADDR-1:0];
      end
      WR: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_q + cnt_q[N_ADDR-1:0];
        mem_din  = mem_dout;
      end
      FILL: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = dst_q + cnt_q[N_ADDR-1:0];
        mem_din  = fill_q;
      end
      DONE: begin
        done    = 1'b1;
        aborted = aborted_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_dma.sv
// Scoreboarded bench for sram_dma with an attached SRAM model. Each start
// pushes its expected completion (cycle, aborted, busy and enable cycle
// counts); a negedge monitor pops and compares on every done pulse.
// Memory contents are checked through the SRAM array after each transfer.
module tb_sram_dma;
  import sram_dma_pkg::*;

  localparam int N_WIDTH = 32;
  localparam int N_ADDR  = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               mode = MODE_COPY;
  logic [N_ADDR-1:0]  src = '0;
  logic [N_ADDR-1:0]  dst = '0;
  logic [N_ADDR:0]    len = '0;
  logic [N_WIDTH-1:0] fill_val = '0;
  logic               abort = 1'b0;
  logic               busy, done, aborted, mem_en, mem_we;
  logic [N_ADDR-1:0]  mem_addr;
  logic [N_WIDTH-1:0] mem_din, mem_dout;

  sram_dma #(.N_WIDTH(N_WIDTH), .N_ADDR(N_ADDR)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src),
    .dst(dst), .len(len), .fill_val(fill_val), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  sram #(.N_WIDTH(N_WIDTH), .N_ADDR(N_ADDR)) u_sram (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .din(mem_din), .dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int   cyc;
    logic abt;
    int   busy_n;
    int   en_n;
  } exp_t;

  exp_t sb[$];

  // Monitor: count busy/enable cycles and score each done pulse.
  int busy_n = 0;
  int en_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_n = 0;
      en_n   = 0;
    end else begin
      if (busy)   busy_n++;
      if (mem_en) en_n++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("aborted", aborted, e.abt);
          check("busy_cycles", busy_n, e.busy_n);
          check("en_cycles", en_n, e.en_n);
        end
        busy_n = 0;
        en_n   = 0;
      end
    end
  end

  // Issue one transfer and wait for done. abort_at/restart_at are the index
  // of the negedge after edge E(k-1) where that one-cycle pulse is driven.
  task automatic run(input logic m, input int s, input int d, input int l,
                     input logic [31:0] fv, input int lat, input logic abt,
                     input int bcyc, input int ecyc,
                     input int abort_at, input int restart_at);
    exp_t e;
    bit   got;
    @(negedge clk);
    mode = m; src = N_ADDR'(s); dst = N_ADDR'(d); len = (N_ADDR+1)'(l);
    fill_val = fv; start = 1'b1;
    e.cyc = cyc + 1 + lat; e.abt = abt; e.busy_n = bcyc; e.en_n = ecyc;
    sb.push_back(e);
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      start = (k == restart_at);
      abort = (k == abort_at);
      if (k == restart_at) begin
        mode = MODE_FILL; dst = 10'h300; len = 11'd2; fill_val = 32'h1234_5678;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!got) check("done_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rdm(input int a);
    return u_sram.mem[a];
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) u_sram.mem[i] = 32'h5555_0000 | i;
    for (int i = 0; i < 4; i++)    u_sram.mem[16'h10 + i] = 32'hA0A0_0000 + i;
    for (int i = 0; i < 8; i++)    u_sram.mem[16'h20 + i] = 32'hC0C0_0000 + i;

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Copy 4 words 0x010 -> 0x100: done in the cycle after E8.
    run(MODE_COPY, 'h10, 'h100, 4, 0, 8, 0, 8, 8, -1, -1);
    for (int i = 0; i < 4; i++) check("copy_data", rdm('h100 + i), 32'hA0A0_0000 + i);
    check("copy_after", rdm('h104), 32'h5555_0104);

    // Fill wrapping past the top of memory.
    run(MODE_FILL, 0, 'h3FE, 4, 32'hDEAD_BEEF, 4, 0, 4, 4, -1, -1);
    check("fill_3fe", rdm('h3FE), 32'hDEAD_BEEF);
    check("fill_3ff", rdm('h3FF), 32'hDEAD_BEEF);
    check("fill_000", rdm('h000), 32'hDEAD_BEEF);
    check("fill_001", rdm('h001), 32'hDEAD_BEEF);
    check("fill_002", rdm('h002), 32'h5555_0002);
    check("fill_3fd", rdm('h3FD), 32'h5555_03FD);

    // Zero length: done right after E0, no SRAM activity.
    run(MODE_COPY, 'h10, 'h180, 0, 0, 0, 0, 0, 0, -1, -1);
    check("len0_untouched", rdm('h180), 32'h5555_0180);

    // Abort pulsed during the 3rd RD: three words land, 4th untouched.
    run(MODE_COPY, 'h20, 'h140, 8, 0, 6, 1, 6, 6, 5, -1);
    for (int i = 0; i < 3; i++) check("abort_data", rdm('h140 + i), 32'hC0C0_0000 + i);
    check("abort_4th", rdm('h143), 32'h5555_0143);

    // Start reasserted mid-transfer with fill parameters is ignored.
    run(MODE_COPY, 'h10, 'h200, 4, 0, 8, 0, 8, 8, -1, 3);
    for (int i = 0; i < 4; i++) check("restart_data", rdm('h200 + i), 32'hA0A0_0000 + i);
    check("restart_no_fill0", rdm('h300), 32'h5555_0300);
    check("restart_no_fill1", rdm('h301), 32'h5555_0301);

    // Reset during the WR of word 2.
    @(negedge clk);
    mode = MODE_COPY; src = 10'h10; dst = 10'h180; len = 11'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_en", mem_en, 0);
    check("arst_we", mem_we, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_din", mem_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("arst_w0", rdm('h180), 32'hA0A0_0000);
    check("arst_w1", rdm('h181), 32'hA0A0_0001);
    check("arst_w2", rdm('h182), 32'h5555_0182);

    run(MODE_COPY, 'h12, 'h1C0, 2, 0, 4, 0, 4, 4, -1, -1);
    check("post_rst_0", rdm('h1C0), 32'hA0A0_0002);
    check("post_rst_1", rdm('h1C1), 32'hA0A0_0003);

    // Overlapping copy with dst = src+1: the first word propagates.
    u_sram.mem[16'h30] = 32'hB0B0_0000;
    run(MODE_COPY, 'h30, 'h31, 3, 0, 6, 0, 6, 6, -1, -1);
    check("ovl_31", rdm('h31), 32'hB0B0_0000);
    check("ovl_32", rdm('h32), 32'hB0B0_0000);
    check("ovl_33", rdm('h33), 32'hB0B0_0000);
    check("ovl_34", rdm('h34), 32'h5555_0034);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
